// File: rtl/dmem_waitstate.sv
// ---------------------------------------------------------------------------
// dmem_waitstate
//   Multi-cycle data memory for the MA stage. A request is captured in IDLE,
//   held for LATENCY wait cycles, committed on the last WAIT edge, and the
//   result is presented for a single ACK cycle. Supports RV32 byte, half and
//   word loads (sign or zero extended) and stores. Misaligned, illegal or
//   conflicting requests are flagged with ERR and suppressed.
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-low reset
//   READ[3:0]    in   [3] read enable, [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   WRITE[2:0]   in   [2] write enable, [1:0] size (SB/SH/SW)
//   ADDRESS      in   byte address (upper bits ignored, wraps modulo depth)
//   WRITEDATA    in   right-aligned store data
//   READDATA     out  extended load result, valid in ACK, held in IDLE
//   BUSYWAIT     out  high while a request is pending (combinational)
//   ERR          out  request was rejected, valid in ACK only
//   STALL_CYCLES out  saturating count of cycles with BUSYWAIT high
// ---------------------------------------------------------------------------
module dmem_waitstate #(
  parameter int ADDR_WIDTH  = 8,
  parameter int LATENCY     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [3:0]             READ,
  input  logic [2:0]             WRITE,
  input  logic [31:0]            ADDRESS,
  input  logic [31:0]            WRITEDATA,
  output logic [31:0]            READDATA,
  output logic                   BUSYWAIT,
  output logic                   ERR,
  output logic [STALL_CNT_W-1:0] STALL_CYCLES
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                r_state, w_next_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_read;
  logic [2:0]            r_write;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_req;
  logic                  w_commit;
  logic                  w_is_read, w_is_write;
  logic [1:0]            w_size;
  logic                  w_illegal, w_misalign, w_err;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word, w_rdata, w_wdata_rep;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_be;
  logic                  w_unused_addr;

  assign w_req         = READ[3] | WRITE[2];
  assign w_unused_addr = ^ADDRESS[31:ADDR_WIDTH+2];

  // ------------------------------------------------------------------ FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT = w_req && (r_state != S_ACK);
    w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
  end

  // --------------------------------------------------------- request decode
  assign w_is_read  = r_read[3];
  assign w_is_write = r_write[2];
  assign w_size     = w_is_read ? r_read[1:0] : r_write[1:0];

  always_comb begin
    w_illegal = 1'b0;
    if (w_is_read && (r_read[1:0] == 2'b11 || (r_read[2] && r_read[1])))
      w_illegal = 1'b1;
    if (w_is_write && r_write[1:0] == 2'b11)
      w_illegal = 1'b1;
    if (w_is_read && w_is_write)
      w_illegal = 1'b1;
  end

  assign w_misalign = (w_size == 2'b01 && r_addr[0]) ||
                      (w_size == 2'b10 && r_addr[1:0] != 2'b00);
  assign w_err      = w_illegal | w_misalign;

  // ---------------------------------------------------------- load datapath
  assign w_idx  = r_addr[ADDR_WIDTH+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_byte  = w_word[8*r_addr[1:0] +: 8];
    w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_rdata = '0;
    case (r_read[1:0])
      2'b00:   w_rdata = r_read[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_rdata = r_read[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_rdata = w_word;
      default: w_rdata = '0;
    endcase
  end

  // --------------------------------------------------------- store datapath
  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_write[1:0])
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // NOTE: the storage array has no reset; contents survive RST and the
  // array maps onto plain RAM. A pending write is dropped by reset because
  // the asynchronous reset has already forced the FSM out of WAIT.
  always_ff @(posedge CLK) begin
    if (w_commit && w_is_write && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
    end
  end

  // ----------------------------------------------- capture, result, counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_read       <= '0;
      r_write      <= '0;
      READDATA     <= '0;
      ERR          <= 1'b0;
      STALL_CYCLES <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= ADDRESS[ADDR_WIDTH+1:0];
        r_wdata <= WRITEDATA;
        r_read  <= READ;
        r_write <= WRITE;
        r_cnt   <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Stores leave READDATA holding the previous load result.
      if (w_commit) begin
        ERR <= w_err;
        if (w_err)          READDATA <= '0;
        else if (w_is_read) READDATA <= w_rdata;
      end else if (r_state == S_ACK) begin
        ERR <= 1'b0;
      end

      if (BUSYWAIT && STALL_CYCLES != '1)
        STALL_CYCLES <= STALL_CYCLES + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_waitstate.sv
// ---------------------------------------------------------------------------
// tb_dmem_waitstate
//   Directed bench for dmem_waitstate. A default-parameter instance covers
//   loads, stores, errors, wrap and reset; a second instance with a 2-bit
//   stall counter covers saturation. Inputs change just after the falling
//   edge and outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_dmem_waitstate;

  localparam logic [3:0] RD_LB  = 4'b1000;
  localparam logic [3:0] RD_LH  = 4'b1001;
  localparam logic [3:0] RD_LW  = 4'b1010;
  localparam logic [3:0] RD_LBU = 4'b1100;
  localparam logic [3:0] RD_LHU = 4'b1101;
  localparam logic [3:0] RD_NO  = 4'b0000;
  localparam logic [2:0] WR_SB  = 3'b100;
  localparam logic [2:0] WR_SH  = 3'b101;
  localparam logic [2:0] WR_SW  = 3'b110;
  localparam logic [2:0] WR_NO  = 3'b000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, ERR;
  logic [15:0] STALL_CYCLES;

  logic [3:0]  s_read;
  logic [2:0]  s_write;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_busy, s_err;
  logic [1:0]  s_stall;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_waitstate dut (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .ERR(ERR), .STALL_CYCLES(STALL_CYCLES)
  );

  dmem_waitstate #(.STALL_CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .READ(s_read), .WRITE(s_write), .ADDRESS(s_addr),
    .WRITEDATA(s_wdata), .READDATA(s_rdata), .BUSYWAIT(s_busy),
    .ERR(s_err), .STALL_CYCLES(s_stall)
  );

  // Drives one request, counts BUSYWAIT-high cycles and captures the ACK
  // outputs; the request is dropped during ACK so it is not re-issued.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int busy);
    bit done = 0;
    busy  = 0;
    rdata = '0;
    err   = 1'b0;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (BUSYWAIT) begin
        busy++;
        @(negedge CLK);
        #1;
      end else begin
        rdata = READDATA;
        err   = ERR;
        done  = 1;
      end
    end
    READ = RD_NO; WRITE = WR_NO;
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h: no ACK within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; READ = RD_NO; WRITE = WR_NO; ADDRESS = '0; WRITEDATA = '0;
    s_read = RD_NO; s_write = WR_NO; s_addr = '0; s_wdata = '0;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (READDATA !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", READDATA); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ERR); end
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
    checks++; if (STALL_CYCLES !== 16'h0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", STALL_CYCLES); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int busy;
    access(RD_NO, WR_SW, 32'h10, 32'hDEADBEEF, rd, er, busy);
    checks++; if (busy !== 3) begin errors++; $display("FAIL sw_busy_cycles got=%0d exp=3", busy); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err got=%b exp=0", er); end
    access(RD_LW, WR_NO, 32'h10, 32'h0, rd, er, busy);
    checks++; if (busy !== 3) begin errors++; $display("FAIL lw_busy_cycles got=%0d exp=3", busy); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got=%b exp=0", er); end
    @(negedge CLK);
    #1;
    checks++; if (READDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold got=%h exp=deadbeef", READDATA); end
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL idle_busywait got=%b exp=0", BUSYWAIT); end
  endtask

  task automatic test_subword_loads();
    logic [3:0]  ops  [4] = '{RD_LB, RD_LBU, RD_LH, RD_LHU};
    logic [31:0] addrs[4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    logic [31:0] rd; logic er; int busy;
    for (int i = 0; i < 4; i++) begin
      access(ops[i], WR_NO, addrs[i], 32'h0, rd, er, busy);
      checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL subword_load%0d addr=%h got=%h err=%b exp=%h err=0", i, addrs[i], rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int busy;
    access(RD_NO, WR_SB, 32'h11, 32'hFFFFFF55, rd, er, busy);
    access(RD_LW, WR_NO, 32'h10, 32'h0, rd, er, busy);
    checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge got=%h exp=dead55ef", rd); end
    access(RD_NO, WR_SH, 32'h12, 32'hFFFF1234, rd, er, busy);
    access(RD_LW, WR_NO, 32'h10, 32'h0, rd, er, busy);
    checks++; if (rd !== 32'h123455EF) begin errors++; $display("FAIL sh_merge got=%h exp=123455ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int busy;
    access(RD_LW, WR_NO, 32'h11, 32'h0, rd, er, busy);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign got err=%b data=%h exp err=1 data=0", er, rd); end
    access(RD_NO, WR_SH, 32'h13, 32'hFFFFFFFF, rd, er, busy);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misalign got err=%b exp=1", er); end
    access(4'b1011, WR_NO, 32'h10, 32'h0, rd, er, busy);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL bad_funct3 got err=%b exp=1", er); end
    access(RD_NO, 3'b111, 32'h10, 32'h0, rd, er, busy);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL bad_store_size got err=%b exp=1", er); end
    access(RD_LW, WR_SW, 32'h10, 32'h0, rd, er, busy);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rw_conflict got err=%b exp=1", er); end
    access(RD_LW, WR_NO, 32'h10, 32'h0, rd, er, busy);
    checks++; if (rd !== 32'h123455EF || er !== 1'b0) begin errors++; $display("FAIL after_errors got=%h err=%b exp=123455ef err=0", rd, er); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int busy;
    access(RD_NO, WR_SW, 32'h400, 32'hA5A5A5A5, rd, er, busy);
    access(RD_LW, WR_NO, 32'h000, 32'h0, rd, er, busy);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap got=%h exp=a5a5a5a5", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int busy;
    access(RD_NO, WR_SW, 32'h20, 32'h0BADF00D, rd, er, busy);
    @(negedge CLK);
    READ = RD_NO; WRITE = WR_SW; ADDRESS = 32'h20; WRITEDATA = 32'h11111111;
    @(negedge CLK);                       // request now sitting in WAIT
    RST = 1'b0; WRITE = WR_NO;
    #1;
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rst_busywait got=%b exp=0", BUSYWAIT); end
    checks++; if (STALL_CYCLES !== 16'h0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", STALL_CYCLES); end
    checks++; if (READDATA !== 32'h0) begin errors++; $display("FAIL rst_readdata got=%h exp=0", READDATA); end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    access(RD_LW, WR_NO, 32'h20, 32'h0, rd, er, busy);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rst_write_dropped got=%h exp=0badf00d", rd); end
    checks++; if (STALL_CYCLES !== 16'd3) begin errors++; $display("FAIL stall_count got=%0d exp=3", STALL_CYCLES); end
  endtask

  task automatic test_stall_saturation();
    @(negedge CLK);
    s_read = RD_LW; s_addr = 32'h0;
    #1;
    checks++; if (s_stall !== 2'd0) begin errors++; $display("FAIL sat_start got=%0d exp=0", s_stall); end
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (s_stall !== 2'd2) begin errors++; $display("FAIL sat_counting got=%0d exp=2", s_stall); end
    repeat (18) @(negedge CLK);            // five back-to-back requests total
    #1;
    checks++; if (s_stall !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", s_stall); end
    s_read = RD_NO;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_loads();
    test_partial_store();
    test_errors();
    test_wrap();
    test_reset_mid_wait();
    test_stall_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
